// File: rtl/mul_div_unit.sv
`ifndef instWidth
`define instWidth 32
`endif
// Purpose : multi-cycle RV32M multiply/divide execute unit fed by the EX-stage forwarded operands.
// Latency : start accepted at edge E0 -> done pulses in the cycle after E33 (divide-by-zero/overflow: after E1).
// Backpr. : no handshake; stall_req freezes IF/ID/EX while working, start is ignored while busy, flush aborts.
// Ports   : clk/rst_n (sync, active-low); start/op/operand_a/operand_b request; flush abort;
//           busy, stall_req, done (1-cycle pulse), result (held until the next accepted start completes).
module mul_div_unit #(
    parameter int WIDTH = `instWidth
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             flush,
    output logic             busy,
    output logic             stall_req,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FINISH = 2'd2} state_t;

    localparam logic [5:0]       LAST_ITER = 6'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

    state_t             state_q, state_d;
    logic [5:0]         cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;     // mul: {partial hi, multiplier}; div: {remainder, dividend/quotient}
    logic [WIDTH-1:0]   opnd_q, opnd_d;   // multiplicand or divisor magnitude
    logic [2:0]         op_q, op_d;
    logic               neg_q, neg_d;     // final result must be negated
    logic               done_q, done_d;
    logic [WIDTH-1:0]   result_q, result_d;

    logic               a_signed, b_signed, a_neg, b_neg;
    logic [WIDTH-1:0]   mag_a, mag_b, special_res;
    logic               div_by_zero, div_ovf, special;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] step, prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix, final_res;

    // Operand decode: signedness per funct3, magnitudes, and the two cases that bypass iteration.
    always_comb begin
        a_signed    = op[2] ? ~op[0] : (op[1:0] != 2'b11);
        b_signed    = op[2] ? ~op[0] : ~op[1];
        a_neg       = a_signed & operand_a[WIDTH-1];
        b_neg       = b_signed & operand_b[WIDTH-1];
        mag_a       = a_neg ? -operand_a : operand_a;
        mag_b       = b_neg ? -operand_b : operand_b;
        div_by_zero = op[2] & (operand_b == '0);
        div_ovf     = op[2] & ~op[0] & (operand_a == MIN_NEG) & (operand_b == '1);
        special     = div_by_zero | div_ovf;
        if (div_by_zero) begin
            special_res = op[1] ? operand_a : '1;
        end else begin
            special_res = op[1] ? '0 : MIN_NEG;
        end
    end

    // One radix-2 iteration, plus the sign fix-up applied to the value the last iteration produces.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, opnd_q};
        if (op_q[2]) begin
            // Borrow out of the trial subtraction means restore (quotient bit 0).
            if (div_diff[WIDTH]) begin
                step = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end else begin
                step = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end
        end else begin
            step = {mul_sum, acc_q[WIDTH-1:1]};
        end
        prod_fix = neg_q ? -step : step;
        quot_fix = neg_q ? -step[WIDTH-1:0] : step[WIDTH-1:0];
        rem_fix  = neg_q ? -step[2*WIDTH-1:WIDTH] : step[2*WIDTH-1:WIDTH];
        case (op_q)
            3'b000:                 final_res = prod_fix[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: final_res = prod_fix[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         final_res = quot_fix;
            default:                final_res = rem_fix;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        op_d     = op_q;
        neg_d    = neg_q;
        result_d = result_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d   = op;
                    neg_d  = (op[2] & op[1]) ? a_neg : (a_neg ^ b_neg);
                    opnd_d = mag_b;
                    acc_d  = {{WIDTH{1'b0}}, mag_a};
                    cnt_d  = '0;
                    if (special) begin
                        result_d = special_res;
                        state_d  = FINISH;
                    end else begin
                        state_d  = CALC;
                    end
                end
            end
            CALC: begin
                acc_d = step;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == LAST_ITER) begin
                    result_d = final_res;
                    state_d  = FINISH;
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Flush wins over everything: back to IDLE, no pulse, result untouched.
        if (flush) begin
            state_d  = IDLE;
            cnt_d    = '0;
            result_d = result_q;
            done_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign stall_req = rst_n & (((state_q == IDLE) & start) | (state_q == CALC));
    assign done      = done_q;
    assign result    = result_q;
endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        flush;
    logic        busy;
    logic        stall_req;
    logic        done;
    logic [31:0] result;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .flush     (flush),
        .busy      (busy),
        .stall_req (stall_req),
        .done      (done),
        .result    (result)
    );

    typedef struct {
        logic [31:0] res;
        int          start_cyc;
        int          lat;
        string       tag;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic [31:0] last_res;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Reference behaviour written directly from the RV32M definitions.
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        p  = '0;
        case (f)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(sa / sb);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Called at a falling edge; drives start for one cycle and records the expectation.
    task automatic issue(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] want);
        exp_t e;
        start     = 1'b1;
        op        = f;
        operand_a = a;
        operand_b = b;
        e.res       = want;
        e.start_cyc = cyc + 1;
        e.lat       = is_special(f, a, b) ? 1 : 33;
        e.tag       = tag;
        sb_q.push_back(e);
        last_res = want;
    endtask

    task automatic drain(input string tag);
        int waited = 0;
        while (sb_q.size() != 0 && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        if (sb_q.size() != 0) begin
            chk({tag, " done timeout"}, 32'(sb_q.size()), 32'd0);
            sb_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] want);
        issue(tag, f, a, b, want);
        @(negedge clk);
        start = 1'b0;
        drain(tag);
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding request.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    chk("spurious done", 32'(done), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk({e.tag, " result"}, result, e.res);
                    chk({e.tag, " latency"}, 32'(cyc - e.start_cyc), 32'(e.lat));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
        $fatal(1);
    end

    initial begin
        int          stall_cnt;
        logic [2:0]  f;
        logic [31:0] a, b;

        // Reset with a special-case start held high: reset must win and stall must stay low.
        rst_n = 1'b0; start = 1'b1; op = 3'd5; operand_a = 32'd5; operand_b = 32'd0; flush = 1'b0;
        last_res = '0;
        repeat (2) @(negedge clk);
        chk("reset stall_req", 32'(stall_req), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset result", result, 32'd0);
        rst_n = 1'b1;
        start = 1'b0;
        @(negedge clk);

        // MUL 7 * -3 with stall profile: high from the request cycle through the last CALC cycle.
        issue("mul 7*-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        stall_cnt = 0;
        for (int k = 0; k < 60; k++) begin
            if (k > 0) begin
                @(negedge clk);
                start = 1'b0;
            end
            #1;
            if (done) break;
            if (stall_req) stall_cnt++;
        end
        chk("mul stall cycles", 32'(stall_cnt), 32'd33);
        chk("stall in done cycle", 32'(stall_req), 32'd0);
        chk("busy in done cycle", 32'(busy), 32'd0);
        @(negedge clk);
        drain("mul 7*-3");

        run_op("mulhu max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("mulh -1*-1", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
        run_op("mulhsu -1*max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("div -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_op("rem -7%2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_op("divu 5/0", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF);
        run_op("div ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_op("rem ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
        run_op("remu 5%0", 3'd7, 32'd5, 32'd0, 32'd5);
        run_op("divu 100/7", 3'd5, 32'd100, 32'd7, 32'd14);

        for (int i = 0; i < 16; i++) begin
            f = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            run_op($sformatf("rand%0d op%0d", i, f), f, a, b, model(f, a, b));
        end

        // Flush a DIVU at iteration 10; a new start the very next cycle must be accepted.
        run_op("pre-flush mul", 3'd0, 32'd6, 32'd9, 32'd54);
        start = 1'b1; op = 3'd5; operand_a = 32'd1000; operand_b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush busy", 32'(busy), 32'd0);
        chk("flush done", 32'(done), 32'd0);
        chk("flush result held", result, 32'd54);
        run_op("after flush", 3'd5, 32'd1000, 32'd7, 32'd142);

        // Reset mid-CALC; a special-case start while busy must be ignored.
        start = 1'b1; op = 3'd0; operand_a = 32'd3; operand_b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; op = 3'd5; operand_a = 32'd5; operand_b = 32'd0;
        @(negedge clk);
        start = 1'b0;
        chk("busy start ignored busy", 32'(busy), 32'd1);
        chk("busy start ignored result", result, last_res);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        start = 1'b1;
        @(negedge clk);
        chk("mid reset busy", 32'(busy), 32'd0);
        chk("mid reset done", 32'(done), 32'd0);
        chk("mid reset result", result, 32'd0);
        chk("mid reset stall_req", 32'(stall_req), 32'd0);
        rst_n = 1'b1;
        start = 1'b0;
        repeat (40) @(negedge clk);
        chk("post reset result", result, 32'd0);
        run_op("post reset mul", 3'd0, 32'd12, 32'd12, 32'd144);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
